// File: rtl/seq_nibble_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Imported by the top level and the testbench.
package seq_nibble_adder_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_nibble_adder_cla.sv
// 4-bit carry-lookahead adder used as the per-cycle arithmetic stage.
// Purely combinational: generate/propagate terms feed flat carry equations.
module cla_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single CLA stage,
// LSB nibble first. WIDTH must be a multiple of 4 and at least 8.
module seq_nibble_adder
    import seq_nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [1:0]       o_state
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int CNT_W = $clog2(N);

    // Handshake: i_start is accepted on any rising edge where o_busy is low
    // (IDLE or DONE); o_done pulses for one cycle when sum/cout/ovf are valid.
    seq_state_e r_state;
    seq_state_e w_state_next;

    logic [WIDTH-1:0]        r_a_sh;
    logic [WIDTH-1:0]        r_b_sh;
    logic [WIDTH-NIBBLE-1:0] r_acc_sh;
    logic                    r_carry;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sa;
    logic                    r_sb;
    logic [WIDTH-1:0]        r_sum;
    logic                    r_cout;
    logic                    r_ovf;

    logic [NIBBLE-1:0] w_cla_sum;
    logic              w_cla_cout;
    logic [WIDTH-1:0]  w_result;
    logic              w_accept;
    logic              w_last;

    cla_4_bit u_cla (
        .i_a    (r_a_sh[NIBBLE-1:0]),
        .i_b    (r_b_sh[NIBBLE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_cla_sum),
        .o_cout (w_cla_cout)
    );

    assign w_accept = i_start && (r_state != SEQ_RUN);
    assign w_last   = (r_cnt == CNT_W'(N - 1));
    // Newest nibble lands on top; on the last step this is the full result.
    assign w_result = {w_cla_sum, r_acc_sh};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEQ_IDLE: if (w_accept) w_state_next = SEQ_RUN;
            SEQ_RUN:  if (w_last)   w_state_next = SEQ_DONE;
            SEQ_DONE: w_state_next = w_accept ? SEQ_RUN : SEQ_IDLE;
            default:  w_state_next = SEQ_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            SEQ_RUN:  o_busy = 1'b1;
            SEQ_DONE: o_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_sa    <= i_a[WIDTH-1];
            r_sb    <= i_b[WIDTH-1];
        end else if (r_state == SEQ_RUN) begin
            r_a_sh   <= {{NIBBLE{1'b0}}, r_a_sh[WIDTH-1:NIBBLE]};
            r_b_sh   <= {{NIBBLE{1'b0}}, r_b_sh[WIDTH-1:NIBBLE]};
            r_acc_sh <= w_result[WIDTH-1:NIBBLE];
            r_carry  <= w_cla_cout;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_result;
                r_cout <= w_cla_cout;
                r_ovf  <= (r_sa == r_sb) && (w_cla_sum[NIBBLE-1] != r_sa);
            end
        end
    end

    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_ovf   = r_ovf;
    assign o_state = r_state;

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Bench for seq_nibble_adder: WIDTH=16 directed table and corner sequences,
// WIDTH=32 random sweep, with done-driven scoreboards for both instances.
module tb_seq_nibble_adder;
    import seq_nibble_adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic [1:0]  st16;

    logic        start32 = 1'b0, cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;
    logic [1:0]  st32;

    seq_nibble_adder #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_a(a16), .i_b(b16),
        .i_cin(cin16), .o_busy(busy16), .o_done(done16), .o_sum(sum16),
        .o_cout(cout16), .o_ovf(ovf16), .o_state(st16)
    );

    seq_nibble_adder #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(start32), .i_a(a32), .i_b(b32),
        .i_cin(cin32), .o_busy(busy32), .o_done(done32), .o_sum(sum32),
        .o_cout(cout32), .o_ovf(ovf32), .o_state(st32)
    );

    // Expected results packed as {cout, ovf, sum}, plus accept cycle stamps.
    logic [17:0] exp_q16[$];
    logic [33:0] exp_q32[$];
    int          t_q16[$];
    int          t_q32[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] f;
        logic        v;
        f = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v = (a[31] == b[31]) && (f[31] != a[31]);
        return {f[32], v, f[31:0]};
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            if (exp_q16.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done16_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                check("result16", 64'({cout16, ovf16, sum16}), 64'(exp_q16.pop_front()));
                check("latency16", 64'(cyc), 64'(t_q16.pop_front() + 4));
            end
        end
        if (done32) begin
            if (exp_q32.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done32_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                check("result32", 64'({cout32, ovf32, sum32}), 64'(exp_q32.pop_front()));
                check("latency32", 64'(cyc), 64'(t_q32.pop_front() + 8));
            end
        end
    end

    // Call right after a negedge; returns just after the accepting edge.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [17:0] exp, input bit push);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        if (push) begin
            exp_q16.push_back(exp);
            t_q16.push_back(cyc);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic c);
        a32 = a; b32 = b; cin32 = c; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        exp_q32.push_back(model32(a, b, c));
        t_q32.push_back(cyc);
    endtask

    // Returns at the negedge where done is seen, with the busy-cycle count.
    task automatic wait_done(input bit wide, output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wide ? done32 : done16) begin
                seen = 1'b1;
                break;
            end
            if (wide ? busy32 : busy16) busy_cnt++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done in 40 cycles expected done (wide=%0d)", wide);
        end
    endtask

    initial begin
        int bc;
        int dcount;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h7000, 16'h1000, 1'b1, 16'h8001, 1'b0, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset16_outputs", 64'({busy16, done16, cout16, ovf16, sum16}), 64'd0);
        check("reset16_state", 64'(st16), 64'(SEQ_IDLE));
        check("reset32_outputs", 64'({busy32, done32, cout32, ovf32, sum32}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue16(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].ovf, vecs[i].sum}, 1'b1);
            wait_done(1'b0, bc);
            check("busy16_cycles", 64'(bc), 64'd4);
        end

        // Start pulsed in RUN cycle 2 must be ignored.
        @(negedge clk);
        issue16(16'h0F0F, 16'h0101, 1'b0, {1'b0, 1'b0, 16'h1010}, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'hAAAA; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_done(1'b0, bc);
        repeat (6) @(negedge clk);

        // Reset during RUN cycle 3 aborts; outputs clear and no done follows.
        issue16(16'h1111, 16'h2222, 1'b0, 18'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", 64'({busy16, done16, cout16, ovf16, sum16}), 64'd0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done16) dcount++;
        end
        check("midrst_no_done", 64'(dcount), 64'd0);

        // Back-to-back: second start lands in the first op's DONE cycle.
        @(negedge clk);
        issue16(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000}, 1'b1);
        wait_done(1'b0, bc);
        issue16(16'h0001, 16'h0002, 1'b1, {1'b0, 1'b0, 16'h0004}, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_busy", 64'({busy16, done16}), 64'b10);
            check("b2b_hold", 64'({cout16, ovf16, sum16}), 64'({1'b1, 1'b1, 16'h0000}));
        end
        @(negedge clk);
        check("b2b_done", 64'(done16), 64'd1);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            case (i % 10)
                0:       begin ra = 32'hFFFF_FFFF; rb = $urandom; end
                1:       begin ra = 32'h7FFF_FFFF; rb = $urandom_range(0, 15); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            @(negedge clk);
            issue32(ra, rb, 1'($urandom_range(0, 1)));
            wait_done(1'b1, bc);
            check("busy32_cycles", 64'(bc), 64'd8);
        end

        repeat (10) @(negedge clk);
        check("queue16_drained", 64'(exp_q16.size()), 64'd0);
        check("queue32_drained", 64'(exp_q32.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_nibble_adder.md
Name: seq_nibble_adder

Overview:
Multi-cycle WIDTH-bit adder that streams operands through a single 4-bit carry-lookahead stage, one nibble per clock, LSB nibble first.
- Feeds the existing cla_4_bit with operand nibbles and a registered ripple carry.
- Consumes the cla_4_bit sum and cout outputs.
- Used where area matters more than latency, e.g. address/accumulator updates in the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only when busy=0
a      input   WIDTH  operand A; sampled on the accepting edge only
b      input   WIDTH  operand B; sampled on the accepting edge only
cin    input   1      carry-in; sampled on the accepting edge only
busy   output  1      high while nibbles are being processed
done   output  1      one-cycle pulse; sum/cout/ovf valid from this cycle
sum    output  WIDTH  registered result
cout   output  1      carry out of the MSB
ovf    output  1      two's-complement signed overflow

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; nibble counter, shift registers and carry register all cleared.
- A reset asserted mid-operation aborts the operation. No done is produced and the outputs read zero.
- Constant: N = WIDTH/4.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle; DONE -> IDLE.
- Accept: start=1 while busy=0 (IDLE or DONE) at edge E0 does the following:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0;
  - latch sign bits a[WIDTH-1] and b[WIDTH-1];
  - state<=RUN.
- start while busy=1 is ignored. It is not queued, and operands are not resampled.
- RUN, edge E(i+1), i=0..N-1:
  - cla_4_bit input A = a_sh[3:0], input B = b_sh[3:0], carry-in = carry;
  - a_sh and b_sh shift right by 4;
  - the CLA sum nibble shifts into the top of an internal acc_sh;
  - carry<=CLA cout; cnt<=cnt+1.
- Completion: on edge EN (i=N-1):
  - sum<={CLA sum nibble, acc_sh[WIDTH-1:4]};
  - cout<=CLA cout;
  - ovf<=(sa==sb) && (new sum MSB != sa), where sa/sb are the latched sign bits;
  - state<=DONE.
- Latency: accepting edge E0 to done high is N edges. done is high in the cycle following EN, which is 4 cycles for WIDTH=16. busy is high for exactly N cycles.
- Output hold: sum, cout and ovf change only at completion edges or reset. They hold their values through IDLE and through any following RUN until the next completion.
- Back-to-back: start=1 in the DONE cycle is accepted. Next state is RUN, and done still reads 1 in that cycle for the prior result. No idle gap.
- Arithmetic: result is the modulo-2^WIDTH sum a+b+cin. cout is bit WIDTH of the full sum. Wrap-around is signalled only via cout/ovf.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package/header holds:
  - state encodings SEQ_IDLE=2'd0, SEQ_RUN=2'd1, SEQ_DONE=2'd2;
  - the NIBBLE=4 constant.
- Counter width is clog2(N), derived locally.
- One sub-module: instantiate the existing cla_4_bit as the per-cycle arithmetic stage.
- No other hierarchy.

Test Plan:
- WIDTH=16, start with a=16'h1234, b=16'h4321, cin=0 -> busy high 4 cycles; done pulses 4 cycles after accept; sum=16'h5555, cout=0, ovf=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1. a=16'h0000, b=16'hFFFF, cin=1 -> sum=16'h0000, cout=1, ovf=0.
- Accept 16'h0F0F+16'h0101; pulse start with a=16'hAAAA, b=16'hAAAA during cycle 2 of RUN -> ignored; result sum=16'h1010, done exactly once.
- Assert rst for one cycle during RUN cycle 3 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows.
- Two operations back-to-back:
  - op 1: 16'h8000+16'h8000, cin=0;
  - op 2: 16'h0001+16'h0002, cin=1, with start asserted in op 1's DONE cycle;
  - required: op 1 gives sum=0, cout=1, ovf=1; op 2 gives sum=16'h0004, cout=0, ovf=0 exactly 4 cycles later; op 1 outputs hold until op 2 completes.
- WIDTH=32 random sweep of 1000 operand triples against a reference model -> all match; done always 8 cycles after accept.
